ysyx_25060166_imem_resp: RTL

YSYX_25060166_IMEM_RESP -- requirements
Module: ysyx_25060166_imem_resp

---
 rtl/ysyx_25060166_imem_resp_pkg.sv | 19 +
 rtl/ysyx_25060166_imem_array.sv | 31 +++
 rtl/ysyx_25060166_imem_resp.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ysyx_25060166_imem_resp_pkg.sv
// Shared constants and FSM encodings for the instruction-memory responder.
//   ysyx_25060166_WIDTH : default address/data width
//   ysyx_25060166_BASE  : default byte address of word 0
//   imem_state_e        : responder FSM state encoding (IDLE/WAIT/RESP)
package ysyx_25060166_imem_resp_pkg;

  localparam int unsigned ysyx_25060166_WIDTH = 32;
  localparam logic [31:0] ysyx_25060166_BASE  = 32'h8000_0000;

  // Wait counter is wide enough for LATENCY up to 15
  localparam int unsigned ysyx_25060166_IMEM_CNT_W = 4;

  typedef enum logic [1:0] {
    ysyx_25060166_IMEM_IDLE = 2'd0,
    ysyx_25060166_IMEM_WAIT = 2'd1,
    ysyx_25060166_IMEM_RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/ysyx_25060166_imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port, no reset.
//   i_clk   : clock
//   i_we    : write strobe
//   i_waddr : write word index
//   i_wdata : write word
//   i_raddr : read word index
//   o_rdata : read word (combinational from i_raddr)
module ysyx_25060166_imem_array
  import ysyx_25060166_imem_resp_pkg::*;
#(
  parameter int unsigned WIDTH = ysyx_25060166_WIDTH,
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read is combinational so a same-edge write is seen only after the edge
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ysyx_25060166_imem_resp.sv
// Fixed-latency instruction-fetch responder with image-load port.
//   clk, rst                     : clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr : fetch request (byte address)
//   rsp_valid/rsp_ready          : response handshake
//   rsp_data/rsp_err             : instruction word / misaligned-or-out-of-range flag
//   load_en/load_addr/load_data  : image-load write port (word index)
module ysyx_25060166_imem_resp
  import ysyx_25060166_imem_resp_pkg::*;
#(
  parameter int unsigned      WIDTH   = ysyx_25060166_WIDTH,
  parameter int unsigned      DEPTH   = 4096,
  parameter int unsigned      LATENCY = 2,
  parameter logic [WIDTH-1:0] BASE    = WIDTH'(ysyx_25060166_BASE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [WIDTH-1:0]         load_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = ysyx_25060166_IMEM_CNT_W;

  imem_state_e      r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;
  logic [WIDTH-1:0] r_pend_data;
  logic             r_pend_err;

  logic [WIDTH-1:0] w_off;
  logic [AW-1:0]    w_ridx;
  logic [WIDTH-1:0] w_rdata;
  logic             w_err;
  logic             w_accept;
  logic             w_done;

  // Offset from BASE wraps, so addresses below BASE land far out of range
  assign w_off    = req_addr - BASE;
  assign w_ridx   = w_off[AW+1:2];
  assign w_err    = (req_addr[1:0] != 2'b00) || (w_off >= WIDTH'(DEPTH * 4));
  assign w_accept = req_valid & r_req_ready;
  assign w_done   = r_rsp_valid & rsp_ready;

  ysyx_25060166_imem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .i_clk   (clk),
    .i_we    (load_en),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (w_ridx),
    .o_rdata (w_rdata)
  );

  // Responder FSM; the pending word is held aside so outputs keep their last
  // value until the new response is presented. WAIT lasts LATENCY cycles so
  // rsp_valid rises exactly LATENCY edges after the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ysyx_25060166_IMEM_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_pend_data <= '0;
      r_pend_err  <= 1'b0;
    end else begin
      case (r_state)
        ysyx_25060166_IMEM_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_pend_err  <= w_err;
            r_pend_data <= w_err ? '0 : w_rdata;
            r_cnt       <= CW'(LATENCY - 1);
            r_state     <= ysyx_25060166_IMEM_WAIT;
          end
        end
        ysyx_25060166_IMEM_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_pend_data;
            r_rsp_err   <= r_pend_err;
            r_state     <= ysyx_25060166_IMEM_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ysyx_25060166_IMEM_RESP: begin
          if (w_done) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ysyx_25060166_IMEM_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b0;
          r_state     <= ysyx_25060166_IMEM_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule
